eaglesong_msg_loader: RTL and testbench

Upstream feeder for `eaglesong_digest_top`. It accepts a message as a byte-wide valid/ready stream and packs it little-endian into the 256-bit `input_val` word. It drives `input_length_bytes` and the `start_eval` pulse, then waits for the digest stage's `eval_output_ready`. It captures the 256-bit digest and presents it on a result valid/ready handshake, so one message is in flight at a time.

---
 rtl/eaglesong_msg_loader.sv | 167 ++++++++++++++++
 tb/tb_eaglesong_msg_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eaglesong_msg_loader.sv
// Byte-stream message packer feeding eaglesong_digest_top; one message in flight at a time.
// Optional WAIT timeout is enabled by defining EAGLESONG_LOADER_TIMEOUT_EN.
module eaglesong_msg_loader #(
    parameter int START_PULSE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES     = 120
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [255:0] input_val,
    output logic [6:0]   input_length_bytes,
    output logic         start_eval,
    input  logic [255:0] output_val,
    input  logic         eval_output_ready,
    output logic [255:0] result_val,
    output logic         result_err,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         msg_truncated
);

    if (START_PULSE_CYCLES < 1 || START_PULSE_CYCLES > 7 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 127) begin : g_bad_param
        $error("eaglesong_msg_loader: parameter out of range");
    end

    // Handshakes: a byte moves on in_valid && in_ready, a result on
    // result_valid && result_ready; neither side may retract valid once raised.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] byte_cnt;
    logic [2:0] start_cnt;
    logic       ready_q;

    logic accept;
    logic msg_end;
    logic start_done;
    logic capture;
    logic timeout;
    logic res_accept;

    assign accept     = in_valid && (state == ST_FILL);
    assign msg_end    = accept && (in_last || (byte_cnt == 6'd31));
    assign start_done = (state == ST_START) && (start_cnt == 3'(START_PULSE_CYCLES - 1));
    assign capture    = (state == ST_WAIT) && eval_output_ready && !ready_q;
    assign res_accept = (state == ST_OUT) && result_ready;

    assign in_ready     = (state == ST_FILL);
    assign start_eval   = (state == ST_START);
    assign result_valid = (state == ST_OUT);

`ifdef EAGLESONG_LOADER_TIMEOUT_EN
    logic [6:0] wait_cnt;

    // wait_cnt counts completed WAIT cycles; the last one lands OUT exactly
    // TIMEOUT_CYCLES cycles after WAIT entry.
    assign timeout = (state == ST_WAIT) && (wait_cnt == 7'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 7'd0;
        end else if (state != ST_WAIT) begin
            wait_cnt <= 7'd0;
        end else begin
            wait_cnt <= wait_cnt + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_err <= 1'b0;
        end else if (capture) begin
            result_err <= 1'b0;
        end else if (timeout) begin
            result_err <= 1'b1;
        end
    end
`else
    assign timeout    = 1'b0;
    assign result_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FILL:  if (msg_end) state_next = ST_START;
            ST_START: if (start_done) state_next = ST_WAIT;
            ST_WAIT:  if (capture || timeout) state_next = ST_OUT;
            ST_OUT:   if (res_accept) state_next = ST_FILL;
            default:  state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_val          <= '0;
            input_length_bytes <= 7'd0;
            byte_cnt           <= 6'd0;
            msg_truncated      <= 1'b0;
        end else begin
            msg_truncated <= accept && (byte_cnt == 6'd31) && !in_last;
            if (accept) begin
                input_val[{byte_cnt[4:0], 3'b000} +: 8] <= in_byte;
                byte_cnt <= byte_cnt + 6'd1;
            end
            if (msg_end) begin
                input_length_bytes <= {1'b0, byte_cnt} + 7'd1;
            end
            // Length is deliberately kept until the next message ends.
            if (res_accept) begin
                input_val <= '0;
                byte_cnt  <= 6'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_cnt <= 3'd0;
        end else if (state == ST_START) begin
            start_cnt <= start_cnt + 3'd1;
        end else begin
            start_cnt <= 3'd0;
        end
    end

    // Forcing ready_q high during START hides a level left over from the
    // previous digest, so only a fresh rising edge is captured in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
        end else if (state == ST_START) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= eval_output_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_val <= '0;
        end else if (capture) begin
            result_val <= output_val;
        end else if (timeout) begin
            result_val <= '0;
        end
    end

endmodule

// File: tb/tb_eaglesong_msg_loader.sv
// Directed bench for eaglesong_msg_loader with a simple digest-stage stand-in.
module tb_eaglesong_msg_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [255:0] input_val;
    logic [6:0]   input_length_bytes;
    logic         start_eval;
    logic [255:0] output_val;
    logic         eval_output_ready;
    logic [255:0] result_val;
    logic         result_err;
    logic         result_valid;
    logic         result_ready;
    logic         msg_truncated;

    int total = 0;
    int bad   = 0;
    logic [255:0] exp_q[$];

    localparam logic [255:0] HELLO_VAL = 256'h0A21646C726F77202C6F6C6C6548;
    localparam logic [255:0] HELLO_DIG =
        256'hD6727D073CE7EC1ECA9F52DBD0E4954B3F4DCB6B0B43C25D6162D141247E8664;
    localparam logic [255:0] DIG_A = 256'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [255:0] DIG_B = {8{32'hCAFE_F00D}};
    localparam logic [255:0] DIG_C = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] DIG_D = {8{32'h0BAD_C0DE}};
    localparam logic [255:0] DIG_E = 256'h1234_5678_9ABC_DEF0;

    eaglesong_msg_loader #(.START_PULSE_CYCLES(2), .TIMEOUT_CYCLES(120)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_byte            (in_byte),
        .in_valid           (in_valid),
        .in_last            (in_last),
        .in_ready           (in_ready),
        .input_val          (input_val),
        .input_length_bytes (input_length_bytes),
        .start_eval         (start_eval),
        .output_val         (output_val),
        .eval_output_ready  (eval_output_ready),
        .result_val         (result_val),
        .result_err         (result_err),
        .result_valid       (result_valid),
        .result_ready       (result_ready),
        .msg_truncated      (msg_truncated)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        in_byte  = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_eq("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (start_eval && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic deliver(input logic [255:0] d, input int delay);
        repeat (delay) tick();
        output_val        = d;
        eval_output_ready = 1'b1;
        exp_q.push_back(d);
        tick();
        check_eq("capture_latency", result_valid, 1);
        eval_output_ready = 1'b0;
    endtask

    task automatic accept_result(input int hold, input logic exp_err);
        logic [255:0] exp;
        exp = '0;
        if (exp_q.size() == 0) check_eq("scoreboard_empty", 0, 1);
        else exp = exp_q.pop_front();
        check_eq("result_val", result_val, exp);
        check_eq("result_err", result_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq("hold_valid", result_valid, 1);
            check_eq("hold_val", result_val, exp);
            check_eq("hold_in_ready", in_ready, 0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_eq("post_accept_in_ready", in_ready, 1);
        check_eq("post_accept_valid", result_valid, 0);
        check_eq("post_accept_input_val", input_val, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_input_val"}, input_val, 0);
        check_eq({tag, "_len"}, input_length_bytes, 0);
        check_eq({tag, "_start"}, start_eval, 0);
        check_eq({tag, "_rval"}, result_val, 0);
        check_eq({tag, "_rerr"}, result_err, 0);
        check_eq({tag, "_rvalid"}, result_valid, 0);
        check_eq({tag, "_trunc"}, msg_truncated, 0);
    endtask

    logic [7:0] hello [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                               8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    initial begin
        int n;
        logic [255:0] v;
        rst_n             = 1'b0;
        in_byte           = 8'h00;
        in_valid          = 1'b0;
        in_last           = 1'b0;
        output_val        = '0;
        eval_output_ready = 1'b0;
        result_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // "Hello, world!\n"
        for (int i = 0; i < 14; i++) send_byte(hello[i], i == 13);
        check_eq("hello_val", input_val, HELLO_VAL);
        check_eq("hello_len", input_length_bytes, 14);
        check_eq("hello_in_ready", in_ready, 0);
        check_eq("hello_trunc", msg_truncated, 0);
        wait_start(n);
        check_eq("hello_start_cycles", n, 2);
        check_eq("hello_val_stable", input_val, HELLO_VAL);
        deliver(HELLO_DIG, 3);
        accept_result(0, 1'b0);
        check_eq("hello_len_held", input_length_bytes, 14);

        // 33 bytes, truncated at 32
        for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
        check_eq("trunc_pulse", msg_truncated, 1);
        check_eq("trunc_len", input_length_bytes, 32);
        v = input_val;
        check_eq("trunc_top_byte", v[255:248], 8'h1F);
        check_eq("trunc_low_byte", v[7:0], 8'h00);
        check_eq("trunc_start", start_eval, 1);
        tick();
        check_eq("trunc_pulse_once", msg_truncated, 0);
        wait_start(n);
        check_eq("trunc_start_cycles", n, 1);
        deliver(DIG_A, 2);
        accept_result(0, 1'b0);
        send_byte(8'h20, 1'b1);
        check_eq("second_len", input_length_bytes, 1);
        check_eq("second_val", input_val, 256'h20);
        check_eq("second_trunc", msg_truncated, 0);
        wait_start(n);
        deliver(DIG_B, 5);
        accept_result(10, 1'b0);

        // stale ready level must not be captured
        output_val        = DIG_C;
        eval_output_ready = 1'b1;
        send_byte(8'h5A, 1'b1);
        wait_start(n);
        check_eq("stale_start_cycles", n, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("stale_no_capture", result_valid, 0);
        end
        eval_output_ready = 1'b0;
        tick();
        tick();
        check_eq("stale_still_waiting", result_valid, 0);
        deliver(DIG_D, 0);
        accept_result(0, 1'b0);

`ifdef EAGLESONG_LOADER_TIMEOUT_EN
        send_byte(8'h01, 1'b1);
        wait_start(n);
        n = 0;
        while (!result_valid && n < 200) begin
            tick();
            n++;
        end
        check_eq("timeout_cycles", n, 120);
        exp_q.push_back('0);
        accept_result(0, 1'b1);
`endif

        // reset during WAIT
        send_byte(8'h77, 1'b1);
        wait_start(n);
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        check_all_zero("wait_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_byte(8'hAB, 1'b1);
        check_eq("after_reset_val", input_val, 256'hAB);
        check_eq("after_reset_len", input_length_bytes, 1);
        wait_start(n);
        check_eq("after_reset_start_cycles", n, 2);
        deliver(DIG_E, 1);
        accept_result(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
